// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// elaboration-time helpers used by the TX path (and a later RX path).
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Rounded to the nearest whole clock so the bit-time error stays below half a cycle.
  function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  // Word is zero-extended to 8 bits, which leaves its XOR reduction unchanged.
  function automatic logic parity_bit(input logic [7:0] word, input logic [1:0] mode);
    logic p;
    p = ^word;
    case (mode)
      PARITY_EVEN: return p;
      PARITY_ODD:  return ~p;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
// Read data is presented combinationally from the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: pointer reset alone discards queued words.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; frames leave back-to-back while words
// are queued, with data width, parity, stop bits and baud fixed at elaboration.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int CPB   = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
  localparam int IDX_W = 3;

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CPB < 2) begin : g_bad_baud
    $error("uart_tx_fifo: fewer than 2 clocks per bit");
  end

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd;
  logic                 pop;

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 tx_n;
  logic                 busy_n;
  logic                 bit_end;

  assign o_ready = !fifo_full;
  assign bit_end = (baud_cnt == CNT_W'(CPB - 1));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (i_valid),
    .wr_data (i_data),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  // Next-state logic; a pop always restarts the baud counter at zero.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_n      = par;
    pop        = 1'b0;
    case (state)
      TX_IDLE: begin
        baud_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_rd;
          par_n   = parity_bit(8'(fifo_rd), 2'(PARITY_MODE));
          state_n = TX_START;
        end else begin
          state_n = TX_IDLE;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = TX_DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[DATA_BITS-1:1]};
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_n = '0;
            state_n   = (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = TX_STOP;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
            bit_idx_n = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shreg_n = fifo_rd;
              par_n   = parity_bit(8'(fifo_rd), 2'(PARITY_MODE));
              state_n = TX_START;
            end else begin
              state_n = TX_IDLE;
            end
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n    = TX_IDLE;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so o_tx changes on the same edge as the FSM.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != TX_IDLE);
    case (state_n)
      TX_START:  tx_n = 1'b0;
      TX_DATA:   tx_n = shreg_n[0];
      TX_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      par      <= par_n;
      o_tx     <= tx_n;
      o_busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three configurations (8E1, 7O2, 8N1) at
// 10 clocks per bit with a 4-deep FIFO, each checked cycle by cycle.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;
  localparam int DEPTH  = 4;
  localparam int NI     = 3;

  logic clk;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d) at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DB = (g == 1) ? 7 : 8;
    localparam int PM = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
    localparam int SB = (g == 1) ? 2 : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [7:0] FIRST_WORD = (g == 0) ? 8'hA5 : ((g == 1) ? 8'h41 : 8'h80);

    logic          rst;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [DB-1:0] data;
    logic [CW-1:0] count;
    logic [7:0]    sb_q[$];
    logic          wave_q[$];
    logic          start_due;
    int            acc_cnt;
    logic          done;

    uart_tx_fifo #(
      .CLK_FREQ    (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .DATA_BITS   (DB),
      .PARITY_MODE (PM),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (valid),
      .o_ready      (ready),
      .i_data       (data),
      .o_tx         (tx),
      .o_busy       (busy),
      .o_fifo_count (count)
    );

    // A word is taken whenever valid is high and fewer than DEPTH words wait.
    initial begin : tracker
      forever begin
        @(posedge clk);
        if (!rst && valid && sb_q.size() < DEPTH) begin
          sb_q.push_back(8'(data));
          acc_cnt++;
        end
      end
    end

    // Expected line: one level per clock, expanded from the frame format of each popped word.
    initial begin : monitor
      logic [7:0] w;
      logic       lvl;
      logic       exp_tx;
      logic       exp_busy;
      start_due = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          sb_q.delete();
          wave_q.delete();
          start_due = 1'b0;
          check("reset_tx", g, 32'(tx), 32'd1);
          check("reset_busy", g, 32'(busy), 32'd0);
          check("reset_count", g, 32'(count), 32'd0);
        end else begin
          if (start_due) begin
            w = sb_q.pop_front();
            for (int b = 0; b < 1 + DB + ((PM != 0) ? 1 : 0) + SB; b++) begin
              if (b == 0) lvl = 1'b0;
              else if (b <= DB) lvl = w[b-1];
              else if (PM != 0 && b == DB + 1) lvl = (PM == 1) ? ^w : ~^w;
              else lvl = 1'b1;
              for (int c = 0; c < CPB; c++) wave_q.push_back(lvl);
            end
          end
          if (wave_q.size() != 0) begin
            exp_tx   = wave_q.pop_front();
            exp_busy = 1'b1;
          end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
          end
          check("line", g, 32'(tx), 32'(exp_tx));
          check("busy", g, 32'(busy), 32'(exp_busy));
          check("fifo_count", g, 32'(count), 32'(sb_q.size()));
          check("ready", g, 32'(ready), 32'(sb_q.size() < DEPTH));
          start_due = (wave_q.size() == 0) && (sb_q.size() != 0);
        end
      end
    end

    task automatic push_word(input logic [7:0] w);
      int a;
      int k;
      a     = acc_cnt;
      valid = 1'b1;
      data  = DB'(w);
      for (k = 0; k < 2000 && acc_cnt == a; k++) begin
        @(posedge clk);
        #2;
      end
      valid = 1'b0;
      n_checks++;
      if (acc_cnt == a) begin
        n_fail++;
        $display("FAIL push_timeout (dut %0d): word %0h never accepted", g, w);
      end
    endtask

    task automatic wait_idle();
      int k;
      for (k = 0; k < 5000 && (sb_q.size() != 0 || wave_q.size() != 0 || start_due); k++) begin
        @(posedge clk);
        #2;
      end
      n_checks++;
      if (k == 5000) begin
        n_fail++;
        $display("FAIL drain_timeout (dut %0d): %0d words still queued", g, sb_q.size());
      end
      repeat (3) @(posedge clk);
      #2;
    endtask

    initial begin : stim
      rst     = 1'b1;
      valid   = 1'b0;
      data    = '0;
      done    = 1'b0;
      acc_cnt = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      // single frame of the configuration's reference word
      push_word(FIRST_WORD);
      wait_idle();
      // back-to-back pair on consecutive clocks
      push_word(8'h00);
      push_word(8'hFF);
      wait_idle();
      // six words with valid held: the FIFO fills and backpressures
      for (int i = 0; i < 6; i++) push_word(8'(8'h11 * (i + 1)));
      wait_idle();
      // reset in the middle of the data bits with three words queued
      push_word(8'h55);
      for (int i = 0; i < 3; i++) push_word(8'(8'h30 + i));
      repeat (30) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_reset_tx", g, 32'(tx), 32'd1);
      check("async_reset_busy", g, 32'(busy), 32'd0);
      check("async_reset_count", g, 32'(count), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      // random traffic with sparse valid, mixing idle gaps and full-FIFO periods
      for (int i = 0; i < 1500; i++) begin
        valid = ($urandom_range(0, 15) == 0);
        data  = DB'($urandom);
        @(posedge clk);
        #2;
      end
      valid = 1'b0;
      wait_idle();
      done = 1'b1;
    end
  end

  initial begin : finish_blk
    int t;
    for (t = 0; t < 40000 && !(gi[0].done === 1'b1 && gi[1].done === 1'b1 && gi[2].done === 1'b1); t++) begin
      @(posedge clk);
    end
    n_checks++;
    if (t == 40000) begin
      n_fail++;
      $display("FAIL overall_timeout: stimulus did not complete");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
